// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: next-PC/stall from the pipeline, the instruction memory
// handshake, and the fetched instruction plus status flags toward decode.
interface fetch_unit_if;
    logic [31:0] nextPC;
    logic        stall;
    logic        imemAck;
    logic [31:0] imemData;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] PC;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] instrCount;
    logic        addrErr;
    logic        busErr;

    modport master (
        input  nextPC, stall, imemAck, imemData,
        output imemReq, imemAddr, PC, instr, instrValid, instrCount, addrErr, busErr
    );

    modport slave (
        output nextPC, stall, imemAck, imemData,
        input  imemReq, imemAddr, PC, instr, instrValid, instrCount, addrErr, busErr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE -> FETCH -> VALID loop with an ack timeout
// and a misaligned-target check; any error parks the unit in HALT until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instrCount_q, instrCount_d;
    logic        addrErr_q, addrErr_d;
    logic        busErr_q, busErr_d;
    logic [7:0]  wait_q, wait_d;

    // The wait counter holds the number of ack-less FETCH cycles already spent;
    // an ack always beats the timeout in the final allowed cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instrCount_d = instrCount_q;
        addrErr_d    = addrErr_q;
        busErr_d     = busErr_q;
        wait_d       = wait_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                if (bus.imemAck) begin
                    instr_d = bus.imemData;
                    state_d = VALID;
                end else if (wait_q == WAIT_LAST) begin
                    busErr_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            VALID: begin
                if (!bus.stall) begin
                    instrCount_d = instrCount_q + 32'd1;
                    if (bus.nextPC[1:0] != 2'b00) begin
                        addrErr_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        pc_d    = bus.nextPC;
                        state_d = FETCH;
                        wait_d  = '0;
                    end
                end
            end
            HALT: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            instrCount_q <= '0;
            addrErr_q    <= 1'b0;
            busErr_q     <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instrCount_q <= instrCount_d;
            addrErr_q    <= addrErr_d;
            busErr_q     <= busErr_d;
            wait_q       <= wait_d;
        end
    end

    assign bus.imemReq    = (state_q == FETCH);
    assign bus.instrValid = (state_q == VALID);
    assign bus.imemAddr   = pc_q;
    assign bus.PC         = pc_q;
    assign bus.instr      = instr_q;
    assign bus.instrCount = instrCount_q;
    assign bus.addrErr    = addrErr_q;
    assign bus.busErr     = busErr_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum FETCH cycles without imemAck before bus error; legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port nextPC  input  32  next fetch address from the next-PC logic; sampled only on an advance.
REQ-006 SHALL have port stall  input  1  decode not ready; holds the current instruction.
REQ-007 SHALL have port imemAck  input  1  instruction memory returns data this cycle.
REQ-008 SHALL have port imemData  input  32  instruction word; valid when imemAck=1.
REQ-009 SHALL have port imemReq  output  1  fetch request; high exactly while state=FETCH.
REQ-010 SHALL have port imemAddr  output  32  fetch address; always equal to PC.
REQ-011 SHALL have port PC  output  32  address of the instruction being fetched or held.
REQ-012 SHALL have port instr  output  32  captured instruction word.
REQ-013 SHALL have port instrValid  output  1  instr/PC pair valid for decode; high exactly while state=VALID.
REQ-014 SHALL have port instrCount  output  32  number of completed advances; wraps from 32'hFFFFFFFF to 0.
REQ-015 SHALL have port addrErr  output  1  sticky flag: misaligned nextPC was presented on an advance.
REQ-016 SHALL have port busErr  output  1  sticky flag: imemAck timeout.

Function
REQ-017 SHALL implement four states: IDLE, FETCH, VALID and HALT.
REQ-018 IDLE SHALL last exactly one cycle and SHALL then go to FETCH unconditionally.
REQ-019 In FETCH with imemAck=1, the block SHALL set instr<=imemData and go to VALID (instrValid high on the next cycle).
REQ-020 In FETCH with imemAck=0, a wait counter SHALL increment; at a count of TIMEOUT, without ack, it SHALL set busErr=1 and go to HALT.
REQ-021 The wait counter SHALL clear on every entry to FETCH; an ack in the same cycle the count reaches TIMEOUT SHALL win (no error).
REQ-022 In VALID with stall=1, PC, instr and instrValid SHALL hold unchanged for any number of cycles.
REQ-023 In VALID with stall=0 (advance), the block SHALL set PC<=nextPC, increment instrCount, and go to FETCH.
REQ-024 If nextPC[1:0]!=2'b00 on an advance, the block SHALL set addrErr=1, increment instrCount, go to HALT, and leave PC unchanged.
REQ-025 HALT SHALL be absorbing until reset: imemReq=0, instrValid=0, PC/instr/instrCount frozen.
REQ-026 imemAck SHALL be ignored in every state except FETCH.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles (ack in the first FETCH cycle, no stall).
REQ-028 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 When reset=1 at a clock edge, the block SHALL set state=IDLE, PC=RESET_PC, instr=0, instrValid=0, imemReq=0, instrCount=0, addrErr=0, busErr=0 and wait counter=0.
REQ-030 Reset SHALL take priority over all other inputs, including a pending imemAck or an advance in the same cycle.
REQ-031 Reset during FETCH SHALL abort the request; imemReq SHALL be 0 after the edge, and a late ack in IDLE SHALL be ignored.
REQ-032 Reset SHALL be the only way to clear addrErr, busErr and HALT.

Verification
REQ-033 Reset, then ack on the first FETCH cycle with imemData=32'h20080005, stall=0, nextPC=32'h4 -> instrValid=1 with instr=32'h20080005 and PC=0 at cycle 3; PC=32'h4 and instrCount=1 one cycle later.
REQ-034 VALID with stall=1 for 5 cycles and nextPC changing each cycle -> PC, instr and instrValid constant; on release PC=nextPC of the release cycle.
REQ-035 Advance with nextPC=32'h00000102 -> addrErr=1, state HALT, PC unchanged, imemReq=0 permanently; later acks ignored until reset.
REQ-036 TIMEOUT=4, no ack -> busErr=1 after exactly 4 FETCH cycles; with ack on the 4th cycle instead -> VALID, busErr=0.
REQ-037 Reset asserted mid-FETCH with imemAck=1 in the same cycle -> PC=RESET_PC, instrValid=0, instr=0, instrCount=0; normal fetch resumes after IDLE.
REQ-038 Preload instrCount to 32'hFFFFFFFF by forcing, then advance once -> instrCount=0.
